store_queue: RTL and testbench

//  Parametrised in-order store queue between the memory FU and the data-memory write port.

---
 rtl/store_queue.sv | 154 +++++++++++++++
 tb/tb_store_queue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue.sv
// In-order store queue: holds address-resolved stores until ROB retirement, drains one per cycle
// to the data-memory write port, and forwards lane-aligned data to younger loads.
module store_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int ROB_W  = 5,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [31:0]       alloc_data,
    input  logic [1:0]        alloc_size,
    input  logic [ROB_W-1:0]  alloc_rob_tag,
    input  logic              commit_valid,
    input  logic [ROB_W-1:0]  commit_rob_tag,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_size,
    output logic              fwd_hit,
    output logic              fwd_stall,
    output logic [31:0]       fwd_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [31:0]       wb_data,
    output logic [3:0]        wb_strb,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 2;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    logic              valid_r [DEPTH];
    logic [WA_W-1:0]   waddr_r [DEPTH];
    logic [ROB_W-1:0]  tag_r   [DEPTH];
    logic [3:0]        mask_r  [DEPTH];
    logic [31:0]       data_r  [DEPTH];

    logic [IDX_W-1:0]  head_r;
    logic [IDX_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    logic              full_s;
    logic              alloc_fire_s;
    logic              commit_fire_s;
    logic [3:0]        alloc_mask_s;
    logic [31:0]       alloc_shdata_s;
    logic [3:0]        ld_mask_s;

    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign full        = full_s;
    assign empty       = (count_r == CNT_W'(0));
    assign alloc_ready = !full_s;
    assign count       = count_r;

    // Accept/retire decisions and lane alignment of the incoming store and load.
    always_comb begin
        alloc_fire_s   = alloc_valid && !full_s;
        commit_fire_s  = commit_valid && valid_r[head_r] && (tag_r[head_r] == commit_rob_tag);
        alloc_mask_s   = size_mask(alloc_size) << alloc_addr[1:0];
        alloc_shdata_s = alloc_data << {alloc_addr[1:0], 3'b000};
        ld_mask_s      = size_mask(ld_size) << ld_addr[1:0];
    end

    // Forwarding search: valid entries occupy head..tail-1, so walking back from tail-1 finds the youngest overlap first.
    always_comb begin
        logic found_s;
        found_s   = 1'b0;
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin : search
            logic [IDX_W-1:0] idx_s;
            logic [3:0]       common_s;
            idx_s    = tail_r - IDX_W'(1) - IDX_W'(i);
            common_s = mask_r[idx_s] & ld_mask_s;
            if (ld_valid && !found_s && valid_r[idx_s] &&
                (waddr_r[idx_s] == ld_addr[ADDR_W-1:2]) && (common_s != 4'b0000)) begin
                found_s = 1'b1;
                if (common_s == ld_mask_s) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_r[idx_s];
                end else begin
                    fwd_stall = 1'b1;
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Queue state and write-back register; a commit in the flush cycle is older than the branch and still drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
            end
            head_r   <= IDX_W'(0);
            tail_r   <= IDX_W'(0);
            count_r  <= CNT_W'(0);
            wb_valid <= 1'b0;
            wb_addr  <= ADDR_W'(0);
            wb_data  <= 32'h0;
            wb_strb  <= 4'h0;
        end else begin
            wb_valid <= commit_fire_s;
            if (commit_fire_s) begin
                wb_addr <= {waddr_r[head_r], 2'b00};
                wb_data <= data_r[head_r];
                wb_strb <= mask_r[head_r];
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    valid_r[i] <= 1'b0;
                end
                head_r  <= IDX_W'(0);
                tail_r  <= IDX_W'(0);
                count_r <= CNT_W'(0);
            end else begin
                if (commit_fire_s) begin
                    valid_r[head_r] <= 1'b0;
                    head_r          <= head_r + IDX_W'(1);
                end
                if (alloc_fire_s) begin
                    valid_r[tail_r] <= 1'b1;
                    waddr_r[tail_r] <= alloc_addr[ADDR_W-1:2];
                    tag_r[tail_r]   <= alloc_rob_tag;
                    mask_r[tail_r]  <= alloc_mask_s;
                    data_r[tail_r]  <= alloc_shdata_s;
                    tail_r          <= tail_r + IDX_W'(1);
                end
                case ({alloc_fire_s, commit_fire_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue: a directed vector table for single-cycle behaviour
// plus hand-written sequences for fill/refuse, flush, pointer wrap and reset mid-drain.
module tb_store_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int ROB_W  = 5;
    localparam int CNT_W  = 4;
    localparam int NV     = 23;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [ADDR_W-1:0] alloc_addr;
    logic [31:0]       alloc_data;
    logic [1:0]        alloc_size;
    logic [ROB_W-1:0]  alloc_rob_tag;
    logic              commit_valid;
    logic [ROB_W-1:0]  commit_rob_tag;
    logic              flush;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              fwd_hit;
    logic              fwd_stall;
    logic [31:0]       fwd_data;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic [3:0]        wb_strb;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .alloc_data(alloc_data), .alloc_size(alloc_size), .alloc_rob_tag(alloc_rob_tag),
        .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag), .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_stall(fwd_stall), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_strb(wb_strb),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic        av;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic [4:0]  tg;
        logic        cv;
        logic [4:0]  ct;
        logic        lv;
        logic [31:0] la;
        logic [1:0]  ls;
        logic        e_hit;
        logic        e_stall;
        logic [31:0] e_fd;
        logic [3:0]  e_cnt;
        logic        e_wb;
        logic [31:0] e_wa;
        logic [31:0] e_wd;
        logic [3:0]  e_strb;
    } vec_t;

    vec_t vecs [NV];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic [4:0] tg,
                         input logic cv, input logic [4:0] ct, input logic fl);
        @(negedge clk);
        alloc_valid    = av;
        alloc_addr     = a;
        alloc_data     = d;
        alloc_size     = sz;
        alloc_rob_tag  = tg;
        commit_valid   = cv;
        commit_rob_tag = ct;
        flush          = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          pulses;
        logic [31:0] exp_d;

        reset = 1'b1; alloc_valid = 1'b0; alloc_addr = 32'h0; alloc_data = 32'h0;
        alloc_size = 2'b00; alloc_rob_tag = 5'd0; commit_valid = 1'b0; commit_rob_tag = 5'd0;
        flush = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0; ld_size = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_addr", wb_addr, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_wb_strb", 32'(wb_strb), 32'h0);

        //            av    addr        data          sz     tg     cv    ct     lv    ld_addr     ls     hit   stall fwd_data      cnt   wb    wb_addr     wb_data       strb
        vecs[0]  = '{1'b1, 32'h1000, 32'hDEADBEEF, 2'b10, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[1]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd3, 1'b1, 32'h1000, 2'b10, 1'b1, 1'b0, 32'hDEADBEEF, 4'd0, 1'b1, 32'h1000, 32'hDEADBEEF, 4'hF};
        vecs[2]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[3]  = '{1'b1, 32'h2003, 32'h000000AB, 2'b00, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[4]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h2003, 2'b00, 1'b1, 1'b0, 32'hAB000000, 4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[5]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h2000, 2'b10, 1'b0, 1'b1, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[6]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h2002, 2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[7]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h2403, 2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[8]  = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd4, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd0, 1'b1, 32'h2000, 32'hAB000000, 4'h8};
        vecs[9]  = '{1'b1, 32'h3000, 32'h11111111, 2'b10, 5'd1, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[10] = '{1'b1, 32'h3002, 32'h00002222, 2'b01, 5'd2, 1'b0, 5'd0, 1'b1, 32'h3002, 2'b01, 1'b1, 1'b0, 32'h11111111, 4'd2, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[11] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h3002, 2'b01, 1'b1, 1'b0, 32'h22220000, 4'd2, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[12] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h3000, 2'b10, 1'b0, 1'b1, 32'h0,        4'd2, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[13] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 32'h3001, 2'b00, 1'b1, 1'b0, 32'h11111111, 4'd2, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[14] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd2, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd2, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[15] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd1, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b1, 32'h3000, 32'h11111111, 4'hF};
        vecs[16] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd2, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd0, 1'b1, 32'h3000, 32'h22220000, 4'hC};
        vecs[17] = '{1'b1, 32'h4000, 32'h12345678, 2'b11, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[18] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd7, 1'b1, 32'h4000, 2'b10, 1'b1, 1'b0, 32'h12345678, 4'd0, 1'b1, 32'h4000, 32'h12345678, 4'hF};
        vecs[19] = '{1'b1, 32'h5002, 32'hAABBCCDD, 2'b10, 5'd8, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[20] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd8, 1'b1, 32'h5000, 2'b10, 1'b0, 1'b1, 32'h0,        4'd0, 1'b1, 32'h5000, 32'hCCDD0000, 4'hC};
        vecs[21] = '{1'b1, 32'h6001, 32'h00001234, 2'b01, 5'd9, 1'b0, 5'd0, 1'b0, 32'h0,    2'b00, 1'b0, 1'b0, 32'h0,        4'd1, 1'b0, 32'h0,    32'h0,        4'h0};
        vecs[22] = '{1'b0, 32'h0,    32'h0,        2'b00, 5'd0, 1'b1, 5'd9, 1'b1, 32'h6002, 2'b00, 1'b1, 1'b0, 32'h00123400, 4'd0, 1'b1, 32'h6000, 32'h00123400, 4'h6};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].av, vecs[i].a, vecs[i].d, vecs[i].sz, vecs[i].tg, vecs[i].cv, vecs[i].ct, 1'b0);
            ld_valid = vecs[i].lv;
            ld_addr  = vecs[i].la;
            ld_size  = vecs[i].ls;
            #1;
            check($sformatf("v%0d_fwd_hit", i), 32'(fwd_hit), 32'(vecs[i].e_hit));
            check($sformatf("v%0d_fwd_stall", i), 32'(fwd_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_fd);
            tick;
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wb));
            if (vecs[i].e_wb) begin
                check($sformatf("v%0d_wb_addr", i), wb_addr, vecs[i].e_wa);
                check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wd);
                check($sformatf("v%0d_wb_strb", i), 32'(wb_strb), 32'(vecs[i].e_strb));
            end
        end
        ld_valid = 1'b0;

        // Fill to DEPTH, refuse a 9th alloc, and refuse an alloc even when a commit frees the head.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h7000 + 32'(4 * i), 32'h70000000 + 32'(i), 2'b10, 5'(10 + i), 1'b0, 5'd0, 1'b0);
            tick;
            check($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_alloc_ready", 32'(alloc_ready), 32'd0);
        drive(1'b1, 32'h8000, 32'h88888888, 2'b10, 5'd30, 1'b0, 5'd0, 1'b0);
        tick;
        check("ninth_count", 32'(count), 32'd8);
        drive(1'b1, 32'h8000, 32'h88888888, 2'b10, 5'd30, 1'b1, 5'd10, 1'b0);
        #1;
        check("full_commit_alloc_ready", 32'(alloc_ready), 32'd0);
        tick;
        check("full_commit_count", 32'(count), 32'd7);
        check("full_commit_wb_valid", 32'(wb_valid), 32'd1);
        check("full_commit_wb_addr", wb_addr, 32'h7000);
        check("full_commit_wb_data", wb_data, 32'h70000000);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h8000; ld_size = 2'b10;
        #1;
        check("refused_not_stored_hit", 32'(fwd_hit), 32'd0);
        check("refused_not_stored_stall", 32'(fwd_stall), 32'd0);
        ld_addr = 32'h7004;
        #1;
        check("full_fwd_hit", 32'(fwd_hit), 32'd1);
        check("full_fwd_data", fwd_data, 32'h70000001);
        ld_valid = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'(10 + i), 1'b0);
            tick;
            check($sformatf("drain%0d_wb_valid", i), 32'(wb_valid), 32'd1);
            check($sformatf("drain%0d_wb_addr", i), wb_addr, 32'h7000 + 32'(4 * i));
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Flush with a matching commit of the head and a dropped alloc in the same cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h9000 + 32'(4 * i), 32'h90000000 + 32'(i), 2'b10, 5'(20 + i), 1'b0, 5'd0, 1'b0);
            tick;
        end
        check("preflush_count", 32'(count), 32'd3);
        drive(1'b1, 32'hB000, 32'hBBBBBBBB, 2'b10, 5'd25, 1'b1, 5'd20, 1'b1);
        tick;
        check("flush_wb_valid", 32'(wb_valid), 32'd1);
        check("flush_wb_addr", wb_addr, 32'h9000);
        check("flush_wb_data", wb_data, 32'h90000000);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0);
        ld_valid = 1'b1; ld_addr = 32'h9004; ld_size = 2'b10;
        #1;
        check("flushed_entry_hit", 32'(fwd_hit), 32'd0);
        ld_addr = 32'hB000;
        #1;
        check("flush_alloc_dropped_hit", 32'(fwd_hit), 32'd0);
        ld_valid = 1'b0;
        tick;
        check("flush_wb_pulse_end", 32'(wb_valid), 32'd0);
        drive(1'b1, 32'hA000, 32'hA5A5A5A5, 2'b10, 5'd23, 1'b0, 5'd0, 1'b0);
        tick;
        check("postflush_count", 32'(count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'd23, 1'b0);
        tick;
        check("postflush_wb_valid", 32'(wb_valid), 32'd1);
        check("postflush_wb_addr", wb_addr, 32'hA000);
        check("postflush_wb_data", wb_data, 32'hA5A5A5A5);

        // Twenty alloc/commit pairs to wrap head and tail, then a mismatched tag and an empty commit.
        pulses = 0;
        drive(1'b1, 32'hC000, 32'h0, 2'b10, 5'd0, 1'b0, 5'd0, 1'b0);
        tick;
        for (int k = 1; k < 20; k++) begin
            exp_d = 32'(k - 1) * 32'h01010101;
            drive(1'b1, 32'hC000 + 32'(4 * k), 32'(k) * 32'h01010101, 2'b10, 5'(k), 1'b1, 5'(k - 1), 1'b0);
            tick;
            if (wb_valid) pulses++;
            check($sformatf("wrap%0d_wb_addr", k), wb_addr, 32'hC000 + 32'(4 * (k - 1)));
            check($sformatf("wrap%0d_wb_data", k), wb_data, exp_d);
            check($sformatf("wrap%0d_count", k), 32'(count), 32'd1);
        end
        check("wrap_pulses", 32'(pulses), 32'd19);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'd20, 1'b0);
        tick;
        check("mismatch_wb_valid", 32'(wb_valid), 32'd0);
        check("mismatch_count", 32'(count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'd19, 1'b0);
        tick;
        check("wrap_last_wb_valid", 32'(wb_valid), 32'd1);
        check("wrap_last_wb_addr", wb_addr, 32'hC04C);
        check("wrap_last_count", 32'(count), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'd19, 1'b0);
        tick;
        check("empty_commit_wb_valid", 32'(wb_valid), 32'd0);
        check("empty_commit_count", 32'(count), 32'd0);

        // Reset arriving together with a matching commit drops the store without a write-back.
        drive(1'b1, 32'hD000, 32'hD0D0D0D0, 2'b10, 5'd1, 1'b0, 5'd0, 1'b0);
        tick;
        drive(1'b1, 32'hD004, 32'hD1D1D1D1, 2'b10, 5'd2, 1'b0, 5'd0, 1'b0);
        tick;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'd1, 1'b0);
        reset = 1'b1;
        tick;
        check("rstdrain_wb_valid", 32'(wb_valid), 32'd0);
        check("rstdrain_wb_addr", wb_addr, 32'h0);
        check("rstdrain_count", 32'(count), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 5'd0, 1'b1, 5'd2, 1'b0);
        reset = 1'b0;
        tick;
        check("rstdrain_no_late_wb", 32'(wb_valid), 32'd0);
        check("rstdrain_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
